// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN output stage.
//   state_t          - packer FSM states (exposed on the top as signal 'state')
//   BYTES_PER_WORD   - int8 results per 128-bit memory word
//   INT8_MAX/INT8_MIN- saturation bounds for requantized results
//   quant_int8()     - 32-bit accumulator requantization, used as the shared
//                      reference for the dot-product stage model
package cnn_pkg;

    localparam int BYTES_PER_WORD = 16;
    localparam int INT8_MAX       = 127;
    localparam int INT8_MIN       = -128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // bias add, optional ReLU, round-half-up arithmetic shift, int8 saturation
    function automatic logic [7:0] quant_int8(input logic signed [31:0] data,
                                              input logic signed [31:0] bias,
                                              input logic [4:0]         shift,
                                              input logic               relu_en);
        longint s;
        s = longint'(data) + longint'(bias);
        if (relu_en && s < 0) s = 0;
        if (shift != 5'd0) s = (s + (longint'(1) << (shift - 5'd1))) >>> shift;
        if (s > INT8_MAX) s = INT8_MAX;
        else if (s < INT8_MIN) s = INT8_MIN;
        return 8'(s);
    endfunction

endpackage

// File: rtl/cnn_requant.sv
// cnn_requant: combinational requantizer, accumulator result -> int8 byte.
//   data    - signed accumulator result
//   bias    - signed bias added before everything else
//   shift   - arithmetic right shift (0..31), rounds half up
//   relu_en - clamp negative sums to zero
//   q       - saturated int8 result (two's complement byte)
module cnn_requant
    import cnn_pkg::*;
#(
    parameter int ACC_WIDTH = 32
) (
    input  logic signed [ACC_WIDTH-1:0] data,
    input  logic signed [ACC_WIDTH-1:0] bias,
    input  logic [4:0]                  shift,
    input  logic                        relu_en,
    output logic [7:0]                  q
);

    // One bit for the bias add, one more so the rounding constant cannot overflow.
    localparam int EW = ACC_WIDTH + 2;
    localparam logic signed [EW-1:0] MAX_V = EW'(INT8_MAX);
    localparam logic signed [EW-1:0] MIN_V = EW'(INT8_MIN);

    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] relu_v;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shifted;

    always_comb begin
        sum     = EW'(data) + EW'(bias);
        relu_v  = (relu_en && sum[EW-1]) ? '0 : sum;
        rnd     = (shift == 5'd0) ? '0 : (EW'(1) <<< (shift - 5'd1));
        shifted = (relu_v + rnd) >>> shift;
        if (shifted > MAX_V)      q = 8'h7F;
        else if (shifted < MIN_V) q = 8'h80;
        else                      q = shifted[7:0];
    end

endmodule

// File: rtl/cnn_out_quant_packer.sv
// cnn_out_quant_packer: requantizes a stream of accumulator results to int8,
// packs 16 bytes per word and writes each word through a req/ack port.
//   clk, rst          - clock, asynchronous active-high reset
//   start, cfg_*      - job launch and configuration (latched on start in IDLE)
//   res_valid/res_data/res_ready - incoming result stream
//   wr_req/wr_start_addr/wr_size_bytes/wr_data/wr_ack - memory write port
//   busy, done        - job in progress, one-cycle end-of-job pulse
//
// Handshakes: a result transfers on a rising clk edge where res_valid and
// res_ready are both high; res_ready is high only in COLLECT. A write
// transfers on an edge where wr_req and wr_ack are both high; wr_req,
// wr_start_addr, wr_size_bytes and wr_data hold steady from the first
// request cycle until that edge, and wr_req is low the cycle after.
module cnn_out_quant_packer
    import cnn_pkg::*;
#(
    parameter int ACC_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 19,
    parameter int MEM_DATA_BUS = 128,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       cfg_addr_z,
    input  logic [CNT_WIDTH-1:0]        cfg_num_results,
    input  logic signed [ACC_WIDTH-1:0] cfg_bias,
    input  logic [4:0]                  cfg_shift,
    input  logic                        cfg_relu_en,
    input  logic                        res_valid,
    input  logic signed [ACC_WIDTH-1:0] res_data,
    output logic                        res_ready,
    output logic                        wr_req,
    output logic [ADDR_WIDTH-1:0]       wr_start_addr,
    output logic [4:0]                  wr_size_bytes,
    output logic [MEM_DATA_BUS-1:0]     wr_data,
    input  logic                        wr_ack,
    output logic                        busy,
    output logic                        done
);

    localparam int BPW = MEM_DATA_BUS / 8;

    state_t                  state;
    logic [CNT_WIDTH-1:0]    remaining;
    logic signed [ACC_WIDTH-1:0] bias_q;
    logic [4:0]              shift_q;
    logic                    relu_q;
    logic [7:0]              q_byte;
    logic                    accept;
    logic                    word_full;

    cnn_requant #(.ACC_WIDTH(ACC_WIDTH)) u_requant (
        .data    (res_data),
        .bias    (bias_q),
        .shift   (shift_q),
        .relu_en (relu_q),
        .q       (q_byte)
    );

    assign accept    = res_valid & res_ready;
    // wr_size_bytes doubles as the byte-lane pointer while collecting
    assign word_full = (wr_size_bytes == 5'(BPW - 1));

    // wr_start_addr is the running address; wr_data is the packing register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            remaining     <= '0;
            bias_q        <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            res_ready     <= 1'b0;
            wr_req        <= 1'b0;
            wr_start_addr <= '0;
            wr_size_bytes <= '0;
            wr_data       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bias_q        <= cfg_bias;
                        shift_q       <= cfg_shift;
                        relu_q        <= cfg_relu_en;
                        wr_start_addr <= cfg_addr_z;
                        remaining     <= cfg_num_results;
                        wr_data       <= '0;
                        wr_size_bytes <= '0;
                        busy          <= 1'b1;
                        if (cfg_num_results == '0) begin
                            state <= DONE;
                        end else begin
                            res_ready <= 1'b1;
                            state     <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        for (int k = 0; k < BPW; k++) begin
                            if (wr_size_bytes == 5'(k)) wr_data[8*k +: 8] <= q_byte;
                        end
                        wr_size_bytes <= wr_size_bytes + 5'd1;
                        remaining     <= remaining - 1'b1;
                        if (word_full || remaining == CNT_WIDTH'(1)) begin
                            res_ready <= 1'b0;
                            wr_req    <= 1'b1;
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ack) begin
                        wr_req        <= 1'b0;
                        wr_start_addr <= wr_start_addr + ADDR_WIDTH'(wr_size_bytes);
                        wr_size_bytes <= '0;
                        wr_data       <= '0;
                        if (remaining != '0) begin
                            res_ready <= 1'b1;
                            state     <= COLLECT;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Arriving from WRITE the pulse is already up; a zero-length
                    // job arrives with busy still set and raises it here.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_out_quant_packer.sv
module tb_cnn_out_quant_packer;

    localparam int AW = 19;
    localparam int DW = 128;

    logic               clk;
    logic               rst;
    logic               start;
    logic [AW-1:0]      cfg_addr_z;
    logic [15:0]        cfg_num_results;
    logic signed [31:0] cfg_bias;
    logic [4:0]         cfg_shift;
    logic               cfg_relu_en;
    logic               res_valid;
    logic signed [31:0] res_data;
    logic               res_ready;
    logic               wr_req;
    logic [AW-1:0]      wr_start_addr;
    logic [4:0]         wr_size_bytes;
    logic [DW-1:0]      wr_data;
    logic               wr_ack;
    logic               busy;
    logic               done;

    cnn_out_quant_packer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_addr_z      (cfg_addr_z),
        .cfg_num_results (cfg_num_results),
        .cfg_bias        (cfg_bias),
        .cfg_shift       (cfg_shift),
        .cfg_relu_en     (cfg_relu_en),
        .res_valid       (res_valid),
        .res_data        (res_data),
        .res_ready       (res_ready),
        .wr_req          (wr_req),
        .wr_start_addr   (wr_start_addr),
        .wr_size_bytes   (wr_size_bytes),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .busy            (busy),
        .done            (done)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    int            exp_size_q[$];
    int            vals[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference requantization: real-valued floor of (s + half) / 2^shift.
    function automatic int quant_ref(input int x, input int bias, input int shift, input bit relu);
        longint s;
        real    d;
        s = longint'(x) + longint'(bias);
        if (relu && s < 0) s = 0;
        if (shift > 0) begin
            d = real'(longint'(1) << shift);
            s = longint'($floor((real'(s) + d / 2.0) / d));
        end
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return int'(s);
    endfunction

    task automatic build_exp(input logic [AW-1:0] addr0, input int bias, input int shift, input bit relu);
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        int            k;
        int            q;
        a = addr0;
        w = '0;
        k = 0;
        for (int i = 0; i < vals.size(); i++) begin
            q = quant_ref(vals[i], bias, shift, relu);
            w[8*k +: 8] = 8'(q);
            k++;
            if (k == 16 || i == vals.size() - 1) begin
                exp_q.push_back(w);
                exp_addr_q.push_back(a);
                exp_size_q.push_back(k);
                a = a + AW'(k);
                w = '0;
                k = 0;
            end
        end
    endtask

    function automatic int rand_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 255)) - 128;
            1:       return int'($urandom_range(0, 4000)) - 2000;
            2:       return int'($urandom_range(0, 200000)) - 100000;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic fill_random(input int n);
        vals.delete();
        for (int i = 0; i < n; i++) vals.push_back(rand_val());
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [AW-1:0] addr, input int n, input int bias,
                             input int shift, input bit relu);
        @(negedge clk);
        cfg_addr_z      = addr;
        cfg_num_results = 16'(n);
        cfg_bias        = bias;
        cfg_shift       = 5'(shift);
        cfg_relu_en     = relu;
        start           = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("ready_after_start", res_ready, n != 0);
    endtask

    task automatic run_job(input int ack_delay, input bit hold_valid, input bit inject_start);
        int idx;
        int req_cnt;
        int cyc;
        bit acked_prev;
        bit finished;
        idx        = 0;
        req_cnt    = 0;
        cyc        = 0;
        acked_prev = 1'b0;
        finished   = 1'b0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            check("done_timing", done, acked_prev && exp_q.size() == 0);
            if (acked_prev) begin
                check("req_low_after_ack", wr_req, 1'b0);
                check("resume_after_ack", res_ready || done, 1'b1);
            end
            if (done) begin
                check("busy_with_done", busy, 1'b0);
                check("all_results_taken", idx, vals.size());
                finished  = 1'b1;
                wr_ack    = 1'b0;
                res_valid = 1'b0;
            end else begin
                acked_prev = 1'b0;
                if (wr_req) begin
                    check("no_ready_in_write", res_ready, 1'b0);
                    check("write_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        check("wr_start_addr", wr_start_addr, exp_addr_q[0]);
                        check("wr_size_bytes", wr_size_bytes, exp_size_q[0]);
                        check("wr_data", wr_data, exp_q[0]);
                    end
                    req_cnt++;
                    if (req_cnt > ack_delay) begin
                        wr_ack = 1'b1;
                        if (exp_q.size() != 0) begin
                            void'(exp_q.pop_front());
                            void'(exp_addr_q.pop_front());
                            void'(exp_size_q.pop_front());
                        end
                        acked_prev = 1'b1;
                        req_cnt    = 0;
                    end else begin
                        wr_ack = 1'b0;
                    end
                end else begin
                    wr_ack  = 1'b0;
                    req_cnt = 0;
                end
                if (inject_start && cyc == 3) begin
                    start           = 1'b1;
                    cfg_addr_z      = AW'($urandom);
                    cfg_num_results = 16'($urandom);
                    cfg_bias        = $urandom;
                    cfg_shift       = 5'($urandom);
                    cfg_relu_en     = ~cfg_relu_en;
                end else begin
                    start = 1'b0;
                end
                if (idx < vals.size()) begin
                    res_valid = hold_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
                    res_data  = vals[idx];
                end else begin
                    res_valid = 1'b0;
                    res_data  = $urandom;
                end
                if (res_valid && res_ready) idx++;
                @(posedge clk);
            end
        end
        if (!finished) check("job_timeout", 1'b0, 1'b1);
        wr_ack    = 1'b0;
        res_valid = 1'b0;
        start     = 1'b0;
        check("exp_queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_res_ready"}, res_ready, 1'b0);
        check({pfx, "_wr_req"}, wr_req, 1'b0);
        check({pfx, "_wr_start_addr"}, wr_start_addr, '0);
        check({pfx, "_wr_size_bytes"}, wr_size_bytes, '0);
        check({pfx, "_wr_data"}, wr_data, '0);
        check({pfx, "_busy"}, busy, 1'b0);
        check({pfx, "_done"}, done, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bias_r;
        int shift_r;
        bit relu_r;
        int n_r;
        logic [AW-1:0] addr_r;

        rst             = 1'b1;
        start           = 1'b0;
        cfg_addr_z      = '0;
        cfg_num_results = '0;
        cfg_bias        = '0;
        cfg_shift       = '0;
        cfg_relu_en     = 1'b0;
        res_valid       = 1'b0;
        res_data        = '0;
        wr_ack          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // single full word
        vals.delete();
        for (int i = 0; i < 16; i++) vals.push_back(i);
        build_exp(19'h100, 0, 0, 1'b0);
        check("model_single_word", exp_q[0], 128'h0f0e0d0c0b0a09080706050403020100);
        start_job(19'h100, 16, 0, 0, 1'b0);
        run_job(1, 1'b1, 1'b0);

        // partial tail, ack on first request cycle
        vals.delete();
        for (int i = 0; i < 20; i++) vals.push_back(i);
        build_exp(19'h10, 0, 0, 1'b0);
        start_job(19'h10, 20, 0, 0, 1'b0);
        run_job(0, 1'b0, 1'b0);

        // quant corners, expectations written out by hand
        vals = '{40, 8, -100, 100000, 23};
        exp_q.push_back(128'h01_7f_00_00_02);
        exp_addr_q.push_back(19'h200);
        exp_size_q.push_back(5);
        start_job(19'h200, 5, -8, 4, 1'b1);
        run_job(0, 1'b0, 1'b0);

        vals = '{-100000};
        exp_q.push_back(128'h80);
        exp_addr_q.push_back(19'h300);
        exp_size_q.push_back(1);
        start_job(19'h300, 1, -8, 4, 1'b0);
        run_job(2, 1'b0, 1'b0);

        // backpressure: 7-cycle ack delay with results held valid
        fill_random(40);
        bias_r  = int'($urandom_range(0, 4000)) - 2000;
        shift_r = $urandom_range(0, 12);
        build_exp(19'h1234, bias_r, shift_r, 1'b0);
        start_job(19'h1234, 40, bias_r, shift_r, 1'b0);
        run_job(7, 1'b1, 1'b0);

        // start while busy must not disturb the job
        fill_random(12);
        build_exp(19'h4000, 5, 3, 1'b1);
        start_job(19'h4000, 12, 5, 3, 1'b1);
        run_job(1, 1'b0, 1'b1);

        // zero-length job: busy one cycle, then a done pulse, no write
        start_job(19'h500, 0, 0, 0, 1'b0);
        @(negedge clk);
        check("zero_done_early", done, 1'b0);
        check("zero_no_req_1", wr_req, 1'b0);
        @(negedge clk);
        check("zero_done", done, 1'b1);
        check("zero_busy_low", busy, 1'b0);
        check("zero_no_req_2", wr_req, 1'b0);
        @(negedge clk);
        check("zero_done_once", done, 1'b0);

        // randomized jobs
        for (int j = 0; j < 4; j++) begin
            n_r     = $urandom_range(1, 50);
            bias_r  = int'($urandom);
            shift_r = $urandom_range(0, 31);
            relu_r  = $urandom_range(0, 1);
            addr_r  = AW'($urandom);
            fill_random(n_r);
            build_exp(addr_r, bias_r, shift_r, relu_r);
            start_job(addr_r, n_r, bias_r, shift_r, relu_r);
            run_job($urandom_range(0, 3), $urandom_range(0, 1), 1'b0);
        end

        // reset while a write is pending
        start_job(19'h300, 16, 0, 0, 1'b0);
        for (int c = 0; c < 100 && !wr_req; c++) begin
            @(negedge clk);
            if (!wr_req) begin
                res_valid = 1'b1;
                res_data  = rand_val();
                @(posedge clk);
            end
        end
        check("reached_write", wr_req, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        res_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // new job after reset, address wraps past the top
        fill_random(20);
        build_exp(19'h7fff8, 3, 2, 1'b0);
        check("model_wrap_addr", exp_addr_q[1], 19'h00008);
        start_job(19'h7fff8, 20, 3, 2, 1'b0);
        run_job(1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
